// File: rtl/snn_input_loader.sv
// snn_input_loader
//   Writer side of the input-unit RAM read by snn_core. Packed image bytes
//   from the UART receiver go into a one-deep byte buffer. Each byte is then
//   unpacked LSB first into NUM_BITS one-bit RAM writes. Once the frame is
//   complete the loader pulses start and hands the RAM to the core. It keeps
//   the RAM with the core until done, then captures the classified digit.
//
// Ports
//   clk, rst_n       system clock, asynchronous active-low reset
//   rx_rdy, rx_data  one-cycle byte strobe and byte (bit 0 = lowest address)
//   clr_ovr          synchronous clear of the overrun flag
//   done, digit      core completion pulse and result
//   addr_input_unit  RAM write address (0 while the core owns the RAM)
//   d_input_unit     RAM write data
//   we_input_unit    RAM write enable
//   ram_owner        1 = core drives the RAM address, 0 = loader
//   start            one-cycle start pulse to the core
//   digit_out        last captured digit
//   digit_vld        one-cycle pulse when digit_out updates
//   overrun          sticky: a received byte was dropped
//   busy             loader is not idle
module snn_input_loader #(
    parameter int unsigned NUM_BITS = 784,
    parameter int unsigned ADDR_W   = 10
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              rx_rdy,
    input  logic [7:0]        rx_data,
    input  logic              clr_ovr,
    input  logic              done,
    input  logic [3:0]        digit,
    output logic [ADDR_W-1:0] addr_input_unit,
    output logic              d_input_unit,
    output logic              we_input_unit,
    output logic              ram_owner,
    output logic              start,
    output logic [3:0]        digit_out,
    output logic              digit_vld,
    output logic              overrun,
    output logic              busy
);

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        UNPACK,
        START,
        WAIT_DONE,
        RESULT
    } state_e;

    localparam logic [ADDR_W-1:0] LAST_BIT = ADDR_W'(NUM_BITS - 1);

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] bit_cnt_q, bit_cnt_d;
    logic [7:0]        shift_q, shift_d;
    logic [7:0]        buf_q, buf_d;
    logic              buf_full_q, buf_full_d;
    logic              buf_take;

    logic [ADDR_W-1:0] addr_q, addr_d;
    logic              d_q, d_d;
    logic              we_q, we_d;
    logic              ram_owner_q, ram_owner_d;
    logic              start_q, start_d;
    logic [3:0]        digit_out_q, digit_out_d;
    logic              digit_vld_q, digit_vld_d;
    logic              overrun_q, overrun_d;
    logic              busy_q, busy_d;

    always_comb begin
        state_d     = state_q;
        bit_cnt_d   = bit_cnt_q;
        shift_d     = shift_q;
        buf_d       = buf_q;
        buf_full_d  = buf_full_q;
        buf_take    = 1'b0;
        addr_d      = '0;
        d_d         = 1'b0;
        we_d        = 1'b0;
        ram_owner_d = 1'b0;
        start_d     = 1'b0;
        digit_out_d = digit_out_q;
        digit_vld_d = 1'b0;
        overrun_d   = overrun_q & ~clr_ovr;

        unique case (state_q)
            IDLE, LOAD: begin
                if (buf_full_q) begin
                    buf_take = 1'b1;
                    shift_d  = buf_q;
                    state_d  = UNPACK;
                end
            end
            UNPACK: begin
                we_d      = 1'b1;
                d_d       = shift_q[0];
                addr_d    = bit_cnt_q;
                shift_d   = {1'b0, shift_q[7:1]};
                bit_cnt_d = bit_cnt_q + ADDR_W'(1);
                if (bit_cnt_q[2:0] == 3'd7) begin
                    if (bit_cnt_q == LAST_BIT) begin
                        state_d = START;
                    end else if (buf_full_q) begin
                        // Next byte already waiting: reload without a bubble.
                        buf_take = 1'b1;
                        shift_d  = buf_q;
                    end else begin
                        state_d = LOAD;
                    end
                end
            end
            START: begin
                start_d     = 1'b1;
                ram_owner_d = 1'b1;
                state_d     = WAIT_DONE;
            end
            WAIT_DONE: begin
                ram_owner_d = 1'b1;
                if (done) begin
                    digit_out_d = digit;
                    digit_vld_d = 1'b1;
                    state_d     = RESULT;
                end
            end
            RESULT: begin
                bit_cnt_d = '0;
                state_d   = IDLE;
            end
            default: state_d = IDLE;
        endcase

        // A slot freed by buf_take on this edge can accept the incoming byte.
        if (buf_take) begin
            buf_full_d = 1'b0;
        end
        if (rx_rdy) begin
            if (buf_full_q && !buf_take) begin
                overrun_d = 1'b1;
            end else begin
                buf_d      = rx_data;
                buf_full_d = 1'b1;
            end
        end

        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            bit_cnt_q   <= '0;
            shift_q     <= '0;
            buf_q       <= '0;
            buf_full_q  <= 1'b0;
            addr_q      <= '0;
            d_q         <= 1'b0;
            we_q        <= 1'b0;
            ram_owner_q <= 1'b0;
            start_q     <= 1'b0;
            digit_out_q <= '0;
            digit_vld_q <= 1'b0;
            overrun_q   <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            bit_cnt_q   <= bit_cnt_d;
            shift_q     <= shift_d;
            buf_q       <= buf_d;
            buf_full_q  <= buf_full_d;
            addr_q      <= addr_d;
            d_q         <= d_d;
            we_q        <= we_d;
            ram_owner_q <= ram_owner_d;
            start_q     <= start_d;
            digit_out_q <= digit_out_d;
            digit_vld_q <= digit_vld_d;
            overrun_q   <= overrun_d;
            busy_q      <= busy_d;
        end
    end

    assign addr_input_unit = addr_q;
    assign d_input_unit    = d_q;
    assign we_input_unit   = we_q;
    assign ram_owner       = ram_owner_q;
    assign start           = start_q;
    assign digit_out       = digit_out_q;
    assign digit_vld       = digit_vld_q;
    assign overrun         = overrun_q;
    assign busy            = busy_q;

endmodule
